// File: rtl/relm_code_loader.sv
// relm_code_loader: fills the ring's op memories from a push-style word stream.
// A load is a header (start address, op count) followed by packed data words.
// Each data word is unpacked LSB-first into WOP-bit opcodes, written one per
// cycle to an auto-incrementing op address.
//
// Ports:
//   clk         clock
//   reset_in    synchronous active-high reset
//   push_d      [WD] = strobe, [WD-1:0] = word
//   push_retry  combinational; high = presented word not accepted
//   op_we_out   op-memory write enable (registered)
//   op_wa_out   op address, low WID bits select the PE (registered)
//   op_d_out    opcode (registered)
//   busy_out    high while the loader is away from the address state (registered)
//   done_out    one-cycle pulse at load completion (registered)
module relm_code_loader #(
    parameter int unsigned WID = 2,
    parameter int unsigned WAD = 4,
    parameter int unsigned WD  = 32,
    parameter int unsigned WOP = 5
) (
    input  logic                 clk,
    input  logic                 reset_in,
    input  logic [WD:0]          push_d,
    output logic                 push_retry,
    output logic                 op_we_out,
    output logic [WAD+WID-1:0]   op_wa_out,
    output logic [WOP-1:0]       op_d_out,
    output logic                 busy_out,
    output logic                 done_out
);

    localparam int unsigned WA = WAD + WID;
    localparam int unsigned K  = WD / WOP;
    localparam int unsigned SW = $clog2(K + 1);

    localparam logic [1:0] S_ADDR   = 2'd0;
    localparam logic [1:0] S_COUNT  = 2'd1;
    localparam logic [1:0] S_DATA   = 2'd2;
    localparam logic [1:0] S_UNPACK = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [WA-1:0]  addr_q, addr_d;
    logic [WD-1:0]  rem_q, rem_d;
    logic [WD-1:0]  shift_q, shift_d;
    logic [SW-1:0]  slot_q, slot_d;
    logic           op_we_q, op_we_d;
    logic [WA-1:0]  op_wa_q, op_wa_d;
    logic [WOP-1:0] op_d_q, op_d_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           accept;
    logic [WD-1:0]  word;

    // Producer is stalled only while a data word is being unpacked.
    assign push_retry = (state_q == S_UNPACK);
    assign accept     = push_d[WD] && !push_retry;
    assign word       = push_d[WD-1:0];

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q <= S_ADDR;
            addr_q  <= '0;
            rem_q   <= '0;
            shift_q <= '0;
            slot_q  <= '0;
            op_we_q <= 1'b0;
            op_wa_q <= '0;
            op_d_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            shift_q <= shift_d;
            slot_q  <= slot_d;
            op_we_q <= op_we_d;
            op_wa_q <= op_wa_d;
            op_d_q  <= op_d_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        shift_d = shift_q;
        slot_d  = slot_q;
        op_we_d = 1'b0;
        op_wa_d = op_wa_q;
        op_d_d  = op_d_q;
        done_d  = 1'b0;
        // Busy reflects the state of the current cycle, so it drops one
        // cycle after the done pulse.
        busy_d  = (state_q != S_ADDR);

        case (state_q)
            S_ADDR: begin
                if (accept) begin
                    addr_d  = word[WA-1:0];
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (accept) begin
                    rem_d = word;
                    if (word == '0) begin
                        state_d = S_ADDR;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    shift_d = word;
                    slot_d  = '0;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                op_we_d = 1'b1;
                op_wa_d = addr_q;
                op_d_d  = shift_q[WOP-1:0];
                shift_d = shift_q >> WOP;
                addr_d  = addr_q + WA'(1);
                rem_d   = rem_q - WD'(1);
                slot_d  = slot_q + SW'(1);
                // Unused slots of the final word are simply dropped.
                if (rem_q == WD'(1)) begin
                    state_d = S_ADDR;
                    done_d  = 1'b1;
                end else if (slot_q == SW'(K - 1)) begin
                    state_d = S_DATA;
                end
            end
            default: state_d = S_ADDR;
        endcase
    end

    assign op_we_out = op_we_q;
    assign op_wa_out = op_wa_q;
    assign op_d_out  = op_d_q;
    assign busy_out  = busy_q;
    assign done_out  = done_q;

endmodule

// File: tb/tb_relm_code_loader.sv
// Testbench for relm_code_loader: transaction-level model feeding a scoreboard
// queue; a negedge monitor pops and compares every write / done event.
module tb_relm_code_loader;

    localparam int unsigned WID = 2;
    localparam int unsigned WAD = 4;
    localparam int unsigned WD  = 32;
    localparam int unsigned WOP = 5;
    localparam int unsigned WA  = WAD + WID;
    localparam int unsigned K   = WD / WOP;
    localparam int unsigned NA  = 1 << WA;

    logic          clk = 1'b0;
    logic          reset_in = 1'b1;
    logic [WD:0]   push_d = '0;
    logic          push_retry;
    logic          op_we_out;
    logic [WA-1:0] op_wa_out;
    logic [WOP-1:0] op_d_out;
    logic          busy_out;
    logic          done_out;

    relm_code_loader #(.WID(WID), .WAD(WAD), .WD(WD), .WOP(WOP)) dut (
        .clk        (clk),
        .reset_in   (reset_in),
        .push_d     (push_d),
        .push_retry (push_retry),
        .op_we_out  (op_we_out),
        .op_wa_out  (op_wa_out),
        .op_d_out   (op_d_out),
        .busy_out   (busy_out),
        .done_out   (done_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit           we;
        bit [WA-1:0]  wa;
        bit [WOP-1:0] d;
        bit           done;
        int           cyc;
        int           nret;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] wq[$];

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word; hold it while retry is high (optionally strobing junk).
    task automatic push(input logic [31:0] w, input bit junk, output int p);
        int waitc;
        waitc = 0;
        while (push_retry) begin
            push_d = {junk, 32'($urandom)};
            step();
            waitc++;
            if (waitc > 100) begin
                errors++;
                $display("FAIL retry_timeout: retry still high after %0d cycles", waitc);
                $fatal(1, "stuck");
            end
        end
        push_d = {1'b1, w};
        p = cyc + 1;
        step();
        push_d = {1'b0, 32'($urandom)};
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 1)) begin
            push_d = {1'b0, 32'($urandom)};
            step();
        end
    endtask

    // Model of one load: header then the data words held in wq.
    task automatic load(input logic [31:0] a, input int n, input bit junk);
        int p;
        int rem;
        int addr;
        int k;
        rem  = n;
        addr = int'(a % NA);
        gap(); push(a, junk, p);
        gap(); push(32'(n), junk, p);
        if (n == 0) begin
            exp_q.push_back('{we: 1'b0, wa: '0, d: '0, done: 1'b1, cyc: p, nret: 0});
        end else begin
            foreach (wq[i]) begin
                gap(); push(wq[i], junk, p);
                k = (rem < int'(K)) ? rem : int'(K);
                for (int j = 0; j < k; j++) begin
                    exp_q.push_back('{we: 1'b1, wa: WA'(addr),
                                      d: WOP'((wq[i] >> (j * WOP)) & 32'h1F),
                                      done: (rem - j == 1), cyc: p + 1 + j, nret: n});
                    addr = (addr + 1) % NA;
                end
                rem -= k;
            end
        end
    endtask

    // Monitor: every write or done pulse must match the head of the scoreboard.
    int rc = 0;
    bit prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset_in) rc = 0;
        else if (push_retry === 1'b1) rc++;
        if (op_we_out === 1'b1 || done_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("op_we", op_we_out, e.we);
                chk("done", done_out, e.done);
                if (e.we) begin
                    chk("op_wa", op_wa_out, e.wa);
                    chk("op_d", op_d_out, e.d);
                end
                if (done_out === 1'b1) begin
                    chk("retry_cycles", rc, e.nret);
                    chk("busy_at_done", busy_out, 1);
                    rc = 0;
                end
            end
        end
        if (prev_done) chk("busy_after_done", busy_out, 0);
        prev_done = (done_out === 1'b1);
    end

    initial begin
        int p;
        int t;
        int n;
        logic [31:0] w;

        repeat (3) step();
        chk("rst_we", op_we_out, 0);
        chk("rst_wa", op_wa_out, 0);
        chk("rst_d", op_d_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_retry", push_retry, 0);
        reset_in = 1'b0;
        step();

        wq.delete(); wq.push_back(32'h0000_0C41);
        load(32'd5, 3, 1'b0);

        wq.delete(); wq.push_back(32'h0C41_8820); wq.push_back(32'h0000_001F);
        load(32'd10, 7, 1'b1);

        wq.delete(); wq.push_back(32'(4 | (5 << 5) | (6 << 10)));
        load(32'd62, 3, 1'b0);

        wq.delete();
        load(32'd9, 0, 1'b1);
        wq.delete(); wq.push_back(32'h0000_0062);
        load(32'd33, 2, 1'b0);

        // Reset during the third write of a six-op load.
        push(32'd0, 1'b0, p);
        push(32'd6, 1'b0, p);
        w = $urandom;
        push(w, 1'b0, p);
        for (int j = 0; j < 3; j++)
            exp_q.push_back('{we: 1'b1, wa: WA'(j), d: WOP'((w >> (j * WOP)) & 32'h1F),
                              done: 1'b0, cyc: p + 1 + j, nret: 0});
        while (cyc < p + 3) step();
        reset_in = 1'b1;
        step();
        reset_in = 1'b0;
        chk("abort_we", op_we_out, 0);
        chk("abort_busy", busy_out, 0);
        chk("abort_retry", push_retry, 0);
        chk("abort_wa", op_wa_out, 0);

        wq.delete(); wq.push_back(32'd7);
        load(32'd20, 1, 1'b0);

        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, 15);
            wq.delete();
            for (int i = 0; i < (n + int'(K) - 1) / int'(K); i++) wq.push_back($urandom);
            load($urandom, n, 1'($urandom));
        end

        t = 0;
        while (exp_q.size() > 0 && t < 300) begin
            step();
            t++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
